// File: rtl/act_lut_pkg.sv
// Shared constants, FSM state type and checksum helper for the activation LUT loader
// and the activation stage that reads the LUT.
package act_lut_pkg;

    localparam int unsigned LUT_DEPTH = 256;
    localparam int unsigned LUT_AW    = 8;
    localparam int unsigned LUT_DW    = 8;
    localparam int unsigned LUT_CKW   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck
    } lut_ld_state_e;

    // Running checksum: modular sum of zero-extended bytes.
    function automatic logic [LUT_CKW-1:0] ck_add(input logic [LUT_CKW-1:0] sum,
                                                  input logic [LUT_DW-1:0]  data);
        return sum + {{(LUT_CKW - LUT_DW){1'b0}}, data};
    endfunction

endpackage

// File: rtl/act_lut_loader.sv
// Streams a 256-byte table into the activation LUT write port, checksums it and holds
// the activation stage while loading. Define ACT_LUT_LOADER_SIGN_ORDER_EN for a signed-order stream.
module act_lut_loader
    import act_lut_pkg::*;
#(
    parameter int unsigned DEPTH = LUT_DEPTH,
    parameter int unsigned AW    = LUT_AW,
    parameter int unsigned DW    = LUT_DW,
    parameter int unsigned CKW   = LUT_CKW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [CKW-1:0] exp_sum_i,
    input  logic           s_valid_i,
    input  logic [DW-1:0]  s_data_i,
    output logic           s_ready_o,
    output logic           lut_we_o,
    output logic [AW-1:0]  lut_waddr_o,
    output logic [DW-1:0]  lut_wdata_o,
    output logic           busy_o,
    output logic           act_hold_o,
    output logic           done_o,
    output logic           err_o
);

    localparam logic [AW:0] LastBeat = (AW + 1)'(DEPTH - 1);

    lut_ld_state_e state_q, state_d;

    logic [AW:0]    cnt_q, cnt_d;
    logic [CKW-1:0] sum_q, sum_d;
    logic [CKW-1:0] exp_q, exp_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           we_q, we_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [AW-1:0]  beat_addr;
    logic           beat;

`ifdef ACT_LUT_LOADER_SIGN_ORDER_EN
    // Stream arrives as -128..127; flipping the MSB maps it onto the two's-complement index.
    assign beat_addr = cnt_q[AW-1:0] ^ (AW'(1) << (AW - 1));
`else
    assign beat_addr = cnt_q[AW-1:0];
`endif

    assign beat = s_valid_i && s_ready_o;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (beat && (cnt_q == LastBeat)) begin
                    state_d = StCheck;
                end
            end
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        s_ready_o  = (state_q == StLoad) && !abort_i;
        busy_o     = (state_q != StIdle);
        act_hold_o = (state_q != StIdle);
    end

    // Datapath next-state: counter, checksum, expected sum, flags and write port.
    always_comb begin
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    cnt_d = '0;
                    sum_d = '0;
                    exp_d = exp_sum_i;
                    err_d = 1'b0;
                end
            end
            StLoad: begin
                if (abort_i) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end else if (beat) begin
                    we_d    = 1'b1;
                    waddr_d = beat_addr;
                    wdata_d = s_data_i;
                    cnt_d   = cnt_q + 1'b1;
                    sum_d   = ck_add(sum_q, s_data_i);
                end
            end
            StCheck: begin
                done_d = 1'b1;
                err_d  = abort_i ? 1'b1 : (sum_q != exp_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign lut_we_o    = we_q;
    assign lut_waddr_o = waddr_q;
    assign lut_wdata_o = wdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: expected LUT writes are queued as beats are driven
// and compared when the write port fires; handshake, done/err and reset are checked inline.
module tb_act_lut_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] exp_sum_i = '0;
    logic        s_valid_i = 1'b0;
    logic [7:0]  s_data_i = '0;
    logic        s_ready_o;
    logic        lut_we_o;
    logic [7:0]  lut_waddr_o;
    logic [7:0]  lut_wdata_o;
    logic        busy_o;
    logic        act_hold_o;
    logic        done_o;
    logic        err_o;

    act_lut_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .exp_sum_i  (exp_sum_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .lut_we_o   (lut_we_o),
        .lut_waddr_o(lut_waddr_o),
        .lut_wdata_o(lut_wdata_o),
        .busy_o     (busy_o),
        .act_hold_o (act_hold_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail = 0;
    wr_t         sb_q[$];
    wr_t         mon_e;
    int          wr_idx = 0;
    logic [7:0]  addr_log[256];
    logic [7:0]  last_addr = '0;
    logic [7:0]  stream[256];
    logic [15:0] stream_sum;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_addr(input int k);
        logic [7:0] a;
        a = 8'(k);
`ifdef ACT_LUT_LOADER_SIGN_ORDER_EN
        a = a ^ 8'h80;
`endif
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_stream(input bit rnd);
        stream_sum = '0;
        for (int i = 0; i < 256; i++) begin
            stream[i]  = rnd ? 8'($urandom) : 8'(i);
            stream_sum = stream_sum + {8'h00, stream[i]};
        end
    endtask

    // Write-port monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && lut_we_o) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_write", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("wr_addr", 32'(lut_waddr_o), 32'(mon_e.addr));
                check_eq("wr_data", 32'(lut_wdata_o), 32'(mon_e.data));
            end
            if (wr_idx < 256) addr_log[wr_idx] = lut_waddr_o;
            wr_idx++;
            last_addr = lut_waddr_o;
        end
    end

    task automatic run_load(input logic [15:0] exp, input bit gaps, input int abort_at,
                            input int restart_at, input bit exp_err);
        int   k;
        int   ticks;
        bit   gap_phase;
        logic [7:0] d;
        k = 0;
        ticks = 0;
        gap_phase = 1'b0;
        wr_idx = 0;
        start_i = 1'b1;
        exp_sum_i = exp;
        tick();
        ticks++;
        start_i = 1'b0;
        exp_sum_i = 16'($urandom);
        check_eq("busy_after_start", 32'(busy_o), 32'd1);
        check_eq("hold_after_start", 32'(act_hold_o), 32'd1);
        check_eq("err_cleared_on_start", 32'(err_o), 32'd0);
        while (k < 256) begin
            if (gaps && gap_phase) begin
                s_valid_i = 1'b0;
                s_data_i = 8'($urandom);
                gap_phase = 1'b0;
                tick();
                ticks++;
                continue;
            end
            gap_phase = 1'b1;
            d = stream[k];
            s_valid_i = 1'b1;
            s_data_i = d;
            if (k == abort_at) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                s_valid_i = 1'b0;
                check_eq("abort_done", 32'(done_o), 32'd1);
                check_eq("abort_err", 32'(err_o), 32'd1);
                check_eq("abort_busy", 32'(busy_o), 32'd0);
                check_eq("abort_hold", 32'(act_hold_o), 32'd0);
                check_eq("abort_ready", 32'(s_ready_o), 32'd0);
                tick();
                check_eq("abort_done_pulse", 32'(done_o), 32'd0);
                check_eq("abort_err_sticky", 32'(err_o), 32'd1);
                check_eq("abort_sb_empty", 32'(sb_q.size()), 32'd0);
                check_eq("abort_last_addr", 32'(last_addr), 32'(exp_addr(k - 1)));
                check_eq("abort_write_count", 32'(wr_idx), 32'(k));
                return;
            end
            if (k == restart_at) begin
                start_i = 1'b1;
                exp_sum_i = ~exp;
            end
            check_eq("s_ready", 32'(s_ready_o), 32'd1);
            sb_q.push_back({exp_addr(k), d});
            tick();
            ticks++;
            start_i = 1'b0;
            k++;
        end
        s_valid_i = 1'b0;
        check_eq("check_state_busy", 32'(busy_o), 32'd1);
        check_eq("check_state_ready", 32'(s_ready_o), 32'd0);
        check_eq("check_state_done", 32'(done_o), 32'd0);
        tick();
        ticks++;
        check_eq("done", 32'(done_o), 32'd1);
        check_eq("done_busy", 32'(busy_o), 32'd0);
        check_eq("err", 32'(err_o), 32'(exp_err));
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("write_count", 32'(wr_idx), 32'd256);
        if (!gaps) check_eq("load_cycles", 32'(ticks + 1), 32'd259);
        tick();
        check_eq("done_pulse", 32'(done_o), 32'd0);
        check_eq("err_sticky", 32'(err_o), 32'(exp_err));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(lut_we_o), 32'd0);
        check_eq("rst_waddr", 32'(lut_waddr_o), 32'd0);
        check_eq("rst_wdata", 32'(lut_wdata_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_ready", 32'(s_ready_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ramp stream with the correct checksum.
        fill_stream(1'b0);
        check_eq("ramp_sum_model", 32'(stream_sum), 32'h7F80);
        run_load(16'h7F80, 1'b0, -1, -1, 1'b0);
`ifdef ACT_LUT_LOADER_SIGN_ORDER_EN
        check_eq("order_beat0", 32'(addr_log[0]), 32'h80);
        check_eq("order_beat127", 32'(addr_log[127]), 32'hFF);
        check_eq("order_beat128", 32'(addr_log[128]), 32'h00);
`else
        check_eq("order_beat0", 32'(addr_log[0]), 32'h00);
        check_eq("order_beat127", 32'(addr_log[127]), 32'h7F);
        check_eq("order_beat128", 32'(addr_log[128]), 32'h80);
`endif

        // Wrong checksum: every write still lands, err raised.
        run_load(16'h0000, 1'b0, -1, -1, 1'b1);

        // start together with abort in IDLE: nothing happens, err keeps its value.
        start_i = 1'b1;
        abort_i = 1'b1;
        exp_sum_i = 16'h7F80;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check_eq("idle_abort_busy", 32'(busy_o), 32'd0);
        check_eq("idle_abort_done", 32'(done_o), 32'd0);
        check_eq("idle_abort_err", 32'(err_o), 32'd1);
        tick();

        // Toggling valid: gap cycles produce no writes.
        run_load(16'h7F80, 1'b1, -1, -1, 1'b0);

        // Abort while beat 100 is offered, then a clean load clears err.
        run_load(16'h7F80, 1'b0, 100, -1, 1'b1);
        run_load(16'h7F80, 1'b0, -1, -1, 1'b0);

        // start mid-load with a different exp_sum is ignored.
        run_load(16'h7F80, 1'b0, -1, 50, 1'b0);

        // Random data, checksum from the bench model: correct and off-by-one.
        fill_stream(1'b1);
        run_load(stream_sum, 1'b0, -1, -1, 1'b0);
        run_load(stream_sum + 16'd1, 1'b1, -1, -1, 1'b1);

        // Reset in the middle of a load.
        fill_stream(1'b0);
        wr_idx = 0;
        start_i = 1'b1;
        exp_sum_i = 16'h7F80;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            s_valid_i = 1'b1;
            s_data_i = stream[k];
            sb_q.push_back({exp_addr(k), stream[k]});
            tick();
        end
        check_eq("pre_reset_we", 32'(lut_we_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", 32'(lut_we_o), 32'd0);
        check_eq("mid_rst_waddr", 32'(lut_waddr_o), 32'd0);
        check_eq("mid_rst_wdata", 32'(lut_wdata_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_hold", 32'(act_hold_o), 32'd0);
        check_eq("mid_rst_ready", 32'(s_ready_o), 32'd0);
        check_eq("mid_rst_done", 32'(done_o), 32'd0);
        check_eq("mid_rst_err", 32'(err_o), 32'd0);
        s_valid_i = 1'b0;
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", 32'(busy_o), 32'd0);
        check_eq("post_rst_we", 32'(lut_we_o), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
